// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//
// Purpose:
//   Synchronous consumer of an asynchronous, glitch-prone ripple counter
//   value. The value is brought into the clk domain with a two-flop
//   synchroniser and accepted only once it has been seen unchanged for long
//   enough. A wrap counter extends it into a wide event count. A sticky
//   threshold match is raised, and a valid/ready snapshot port serves the
//   readout stage.
//
// Optional feature (compile-time macro):
//   WRAP_SAT_EN  - when defined, the wrap counter saturates at all-ones.
//                  The overflowing wrap sets the sticky wrap_sat flag.
//                  When undefined, the wrap counter rolls over and wrap_sat
//                  is tied low.
//
// Parameters:
//   CW        width of the ripple counter value q_in
//   EW        width of the wrap counter (extended count is CW+EW bits)
//   STABLE_N  equal synchronised samples needed before a value is accepted
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   q_in        ripple counter output, asynchronous to clk
//   clr         synchronous clear of counts, match and overrun
//   thresh      match threshold, quasi-static
//   count       extended count {wrap counter, accepted value}
//   started     a value has been accepted since reset/clr
//   match       sticky: count >= thresh has been seen
//   snap_req    single-cycle snapshot request
//   snap_data   captured count
//   snap_valid  snapshot held for the consumer
//   snap_ready  consumer accepts the snapshot
//   snap_ovr    sticky: a request was dropped while a snapshot was pending
//   wrap_sat    wrap counter saturated (only with WRAP_SAT_EN)

module ripple_count_monitor #(
   parameter int CW       = 4,
   parameter int EW       = 8,
   parameter int STABLE_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CW-1:0]    q_in,
   input  logic             clr,
   input  logic [CW+EW-1:0] thresh,
   output logic [CW+EW-1:0] count,
   output logic             started,
   output logic             match,
   input  logic             snap_req,
   output logic [CW+EW-1:0] snap_data,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic             snap_ovr,
   output logic             wrap_sat
);

   localparam int XW = CW + EW;
   localparam int RW = $clog2(STABLE_N + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_N);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [CW-1:0] s1_q;
   logic [CW-1:0] s2_q;
   logic [CW-1:0] cand_q, cand_d;
   logic [RW-1:0] run_q, run_d;
   logic          stable;
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] acc_q, acc_d;
   logic [EW-1:0] wrap_q, wrap_d;
   logic          wrap_inc;
   logic          match_q, match_d;
   logic [XW-1:0] snap_data_q, snap_data_d;
   logic          snap_valid_q, snap_valid_d;
   logic          snap_ovr_q, snap_ovr_d;

   assign count      = {wrap_q, acc_q};
   assign started    = (state_q == ST_RUN);
   assign match      = match_q;
   assign snap_data  = snap_data_q;
   assign snap_valid = snap_valid_q;
   assign snap_ovr   = snap_ovr_q;

   // Stability filter: cand holds the most recent synchronised value.
   // run counts how many consecutive cycles it has been seen, and
   // saturates at STABLE_N.
   always_comb begin
      cand_d = cand_q;
      run_d  = run_q;
      if (clr) begin
         cand_d = '0;
         run_d  = '0;
      end else if (s2_q == cand_q) begin
         if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
         end
      end else begin
         cand_d = s2_q;
         run_d  = RW'(1);
      end
   end

   // A value is accepted only while the synchroniser still agrees with the
   // candidate. This requires STABLE_N+1 equal samples, so a value that is
   // visible in s2 for fewer cycles can never be accepted.
   assign stable = (run_q == RUN_MAX) && (s2_q == cand_q);

   // Acceptance FSM. In INIT the first stable value is taken as the start
   // point without a wrap check. In RUN a new value that is numerically
   // smaller than the previous one means the ripple counter has wrapped at
   // least once. Exactly one wrap is counted, however many values were
   // skipped.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      match_d  = match_q;
      wrap_inc = 1'b0;
      if (clr) begin
         state_d = ST_INIT;
         acc_d   = '0;
         match_d = 1'b0;
      end else begin
         if ((state_q == ST_RUN) && (count >= thresh)) begin
            match_d = 1'b1;
         end
         if (stable) begin
            if (state_q == ST_INIT) begin
               acc_d   = cand_q;
               state_d = ST_RUN;
            end else if (cand_q != acc_q) begin
               acc_d    = cand_q;
               wrap_inc = (cand_q < acc_q);
            end
         end
      end
   end

`ifdef WRAP_SAT_EN
   logic sat_q, sat_d;

   // Saturating wrap counter. Once it reaches all-ones, the upper count
   // bits freeze and the overflowing wrap is remembered in sat.
   always_comb begin
      wrap_d = wrap_q;
      sat_d  = sat_q;
      if (clr) begin
         wrap_d = '0;
         sat_d  = 1'b0;
      end else if (wrap_inc) begin
         if (wrap_q == {EW{1'b1}}) begin
            sat_d = 1'b1;
         end else begin
            wrap_d = wrap_q + 1'b1;
         end
      end
   end

   // Sticky saturation flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign wrap_sat = sat_q;
`else
   // Rolling wrap counter, modulo 2^EW.
   always_comb begin
      wrap_d = wrap_q;
      if (clr) begin
         wrap_d = '0;
      end else if (wrap_inc) begin
         wrap_d = wrap_q + 1'b1;
      end
   end

   assign wrap_sat = 1'b0;
`endif

   // Snapshot port. A request is served if nothing is pending, or if the
   // pending snapshot is being consumed in the same cycle. Otherwise the
   // request is dropped and recorded as an overrun. The captured value is
   // the registered count, so a request together with clr sees the
   // pre-clear count.
   always_comb begin
      snap_data_d  = snap_data_q;
      snap_valid_d = snap_valid_q;
      snap_ovr_d   = snap_ovr_q;
      if (snap_req && (!snap_valid_q || snap_ready)) begin
         snap_data_d  = count;
         snap_valid_d = 1'b1;
      end else if (snap_valid_q && snap_ready) begin
         snap_valid_d = 1'b0;
      end
      if (clr) begin
         snap_ovr_d = 1'b0;
      end else if (snap_req && snap_valid_q && !snap_ready) begin
         snap_ovr_d = 1'b1;
      end
   end

   // State registers. The synchroniser and the snapshot holding registers
   // are deliberately left out of clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q         <= '0;
         s2_q         <= '0;
         cand_q       <= '0;
         run_q        <= '0;
         state_q      <= ST_INIT;
         acc_q        <= '0;
         wrap_q       <= '0;
         match_q      <= 1'b0;
         snap_data_q  <= '0;
         snap_valid_q <= 1'b0;
         snap_ovr_q   <= 1'b0;
      end else begin
         s1_q         <= q_in;
         s2_q         <= s1_q;
         cand_q       <= cand_d;
         run_q        <= run_d;
         state_q      <= state_d;
         acc_q        <= acc_d;
         wrap_q       <= wrap_d;
         match_q      <= match_d;
         snap_data_q  <= snap_data_d;
         snap_valid_q <= snap_valid_d;
         snap_ovr_q   <= snap_ovr_d;
      end
   end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor
//
// Purpose:
//   Self-checking bench for ripple_count_monitor. A behavioural reference
//   model runs alongside the main instance. Every snapshot it expects to be
//   captured is pushed into a scoreboard queue. A monitor pops that queue
//   whenever the DUT hands a snapshot over, and compares the visible
//   outputs with the model every cycle. A second instance with a 2-bit
//   wrap counter exercises wrap-around and saturation.

module tb_ripple_count_monitor;

   localparam int CW       = 4;
   localparam int EW       = 8;
   localparam int STABLE_N = 2;
   localparam int XW       = CW + EW;
   localparam int EW2      = 2;
   localparam int XW2      = CW + EW2;

   logic           clk;
   logic           rst;
   logic [CW-1:0]  qIn;
   logic           clr;
   logic [XW-1:0]  thresh;
   logic [XW-1:0]  count;
   logic           started;
   logic           match;
   logic           snapReq;
   logic [XW-1:0]  snapData;
   logic           snapValid;
   logic           snapReady;
   logic           snapOvr;
   logic           wrapSat;

   logic [CW-1:0]  qIn2;
   logic [XW2-1:0] count2;
   logic           started2;
   logic           match2;
   logic [XW2-1:0] snapData2;
   logic           snapValid2;
   logic           snapOvr2;
   logic           wrapSat2;
   logic           dut2Done;

   int nChecks;
   int nFails;

   // Reference model state
   int mS1, mS2, mAcc, mWrap, mSdata, mCnt, mV;
   bit mStarted, mMatch, mSat, mSv, mOvr, mSvPre, mStable;
   int mHist[$];
   int expSnapQ[$];

   ripple_count_monitor #(.CW(CW), .EW(EW), .STABLE_N(STABLE_N)) dut (
      .clk        (clk),
      .rst        (rst),
      .q_in       (qIn),
      .clr        (clr),
      .thresh     (thresh),
      .count      (count),
      .started    (started),
      .match      (match),
      .snap_req   (snapReq),
      .snap_data  (snapData),
      .snap_valid (snapValid),
      .snap_ready (snapReady),
      .snap_ovr   (snapOvr),
      .wrap_sat   (wrapSat)
   );

   ripple_count_monitor #(.CW(CW), .EW(EW2), .STABLE_N(STABLE_N)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .q_in       (qIn2),
      .clr        (1'b0),
      .thresh     ({XW2{1'b1}}),
      .count      (count2),
      .started    (started2),
      .match      (match2),
      .snap_req   (1'b0),
      .snap_data  (snapData2),
      .snap_valid (snapValid2),
      .snap_ready (1'b0),
      .snap_ovr   (snapOvr2),
      .wrap_sat   (wrapSat2)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison: counts it and reports a failure
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive a ripple value and hold it for the given number of clock edges
   task automatic applyStimulus(input int value, input int cycles);
      qIn = value[CW-1:0];
      repeat (cycles) @(negedge clk);
   endtask

   function automatic int modelCount();
      return (mWrap << CW) | mAcc;
   endfunction

   // Reference model. The synchroniser is a plain two-step delay. A value is
   // accepted when the last STABLE_N+1 synchronised samples since reset/clr
   // are all equal. A wrap is any accepted value smaller than the previous one.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mS1 = 0; mS2 = 0; mAcc = 0; mWrap = 0; mSdata = 0;
         mStarted = 0; mMatch = 0; mSat = 0; mSv = 0; mOvr = 0;
         mHist.delete();
         expSnapQ.delete();
      end else begin
         mCnt    = modelCount();
         mSvPre  = mSv;
         mStable = 0;
         mV      = 0;

         if (snapReq && (!mSvPre || snapReady)) begin
            expSnapQ.push_back(mCnt);
            mSdata = mCnt;
            mSv    = 1;
         end else if (mSvPre && snapReady) begin
            mSv = 0;
         end

         if (clr) begin
            mHist.delete();
         end else begin
            mHist.push_back(mS2);
            if (mHist.size() > STABLE_N + 1) void'(mHist.pop_front());
            if (mHist.size() == STABLE_N + 1) begin
               mStable = 1;
               mV      = mHist[0];
               foreach (mHist[i]) if (mHist[i] != mV) mStable = 0;
            end
         end
         mS2 = mS1;
         mS1 = qIn;

         if (clr) begin
            mAcc = 0; mWrap = 0; mStarted = 0; mMatch = 0; mOvr = 0; mSat = 0;
         end else begin
            if (snapReq && mSvPre && !snapReady) mOvr = 1;
            if (mStarted && mCnt >= thresh) mMatch = 1;
            if (mStable) begin
               if (!mStarted) begin
                  mAcc     = mV;
                  mStarted = 1;
               end else if (mV != mAcc) begin
                  if (mV < mAcc) begin
`ifdef WRAP_SAT_EN
                     if (mWrap == (1 << EW) - 1) mSat = 1;
                     else mWrap = mWrap + 1;
`else
                     mWrap = (mWrap + 1) % (1 << EW);
`endif
                  end
                  mAcc = mV;
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each snapshot handshake, then compares
   // the settled outputs with the model shortly after the edge.
   always @(posedge clk) begin
      if (!rst && snapValid && snapReady) begin
         if (expSnapQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL snapScoreboard: handshake with data 0x%0h, expected no pending snapshot", snapData);
         end else begin
            checkOutput("snapHandshake", snapData, expSnapQ.pop_front());
         end
      end
      #1;
      if (!rst) begin
         checkOutput("count", count, modelCount());
         checkOutput("started", started, mStarted);
         checkOutput("match", match, mMatch);
         checkOutput("snapValid", snapValid, mSv);
         checkOutput("snapData", snapData, mSdata);
         checkOutput("snapOvr", snapOvr, mOvr);
         checkOutput("wrapSat", wrapSat, mSat);
      end
   end

   // Narrow instance: five ripple wraps through a 2-bit wrap counter
   initial begin : dut2Stim
      int seq [11];
      int wraps;
      int expUp;
      int expSat;
      seq = '{0, 8, 2, 9, 1, 9, 1, 9, 1, 9, 1};
      dut2Done = 1'b0;
      qIn2     = '0;
      @(negedge clk);
      while (rst) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         qIn2 = seq[i][CW-1:0];
         repeat (8) @(negedge clk);
      end
      wraps = 0;
      for (int i = 1; i < 11; i++) if (seq[i] < seq[i-1]) wraps++;
`ifdef WRAP_SAT_EN
      expUp  = (wraps > (1 << EW2) - 1) ? (1 << EW2) - 1 : wraps;
      expSat = (wraps > (1 << EW2) - 1) ? 1 : 0;
`else
      expUp  = wraps % (1 << EW2);
      expSat = 0;
`endif
      checkOutput("dut2WrapUpper", count2[XW2-1:CW], expUp);
      checkOutput("dut2Lower", count2[CW-1:0], seq[10]);
      checkOutput("dut2WrapSat", wrapSat2, expSat);
      checkOutput("dut2Started", started2, 1);
      dut2Done = 1'b1;
   end

   // Main stimulus: directed scenarios, then randomized traffic
   initial begin
      int hold;
      nChecks   = 0;
      nFails    = 0;
      rst       = 1'b0;
      qIn       = 4'd3;
      clr       = 1'b0;
      snapReq   = 1'b0;
      snapReady = 1'b0;
      thresh    = 12'h010;
      #1 rst = 1'b1;
      #2;
      checkOutput("rstCount", count, 0);
      checkOutput("rstStarted", started, 0);
      checkOutput("rstMatch", match, 0);
      checkOutput("rstSnapData", snapData, 0);
      checkOutput("rstSnapValid", snapValid, 0);
      checkOutput("rstSnapOvr", snapOvr, 0);
      checkOutput("rstWrapSat", wrapSat, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // q_in=3 held from reset: accepted on the fifth edge
      repeat (4) @(negedge clk);
      checkOutput("latEdge4Count", count, 0);
      checkOutput("latEdge4Started", started, 0);
      @(negedge clk);
      checkOutput("latEdge5Count", count, 12'h003);
      checkOutput("latEdge5Started", started, 1);
      checkOutput("latEdge5Match", match, 0);
      applyStimulus(3, 5);

      // Clear, then 0 -> 15 -> 0 gives one wrap and crosses the threshold
      clr = 1'b1;
      qIn = 4'd0;
      @(negedge clk);
      clr = 1'b0;
      applyStimulus(0, 10);
      checkOutput("stepZero", count, 12'h000);
      applyStimulus(15, 10);
      checkOutput("stepFifteen", count, 12'h00F);
      checkOutput("stepFifteenMatch", match, 0);
      applyStimulus(0, 5);
      checkOutput("stepWrap", count, 12'h010);
      checkOutput("stepWrapMatchLag", match, 0);
      @(negedge clk);
      checkOutput("stepWrapMatch", match, 1);
      applyStimulus(0, 4);

      // One-cycle glitch is never accepted
      applyStimulus(5, 10);
      checkOutput("preGlitch", count, 12'h015);
      applyStimulus(7, 1);
      applyStimulus(5, 10);
      checkOutput("postGlitch", count, 12'h015);

      // Snapshot hold and overrun
      applyStimulus(3, 10);
      checkOutput("snapSetup", count, 12'h023);
      snapReq = 1'b1;
      @(negedge clk);
      snapReq = 1'b0;
      checkOutput("snapRise", snapValid, 1);
      checkOutput("snapCaptured", snapData, 12'h023);
      checkOutput("snapNoOvr", snapOvr, 0);
      repeat (2) @(negedge clk);
      snapReq = 1'b1;
      @(negedge clk);
      snapReq = 1'b0;
      checkOutput("snapOvrSet", snapOvr, 1);
      checkOutput("snapHeldValid", snapValid, 1);
      checkOutput("snapHeldData", snapData, 12'h023);
      snapReady = 1'b1;
      @(negedge clk);
      snapReady = 1'b0;
      checkOutput("snapConsumed", snapValid, 0);

      // clr together with snap_req captures the pre-clear count
      applyStimulus(2, 8);
      applyStimulus(1, 8);
      applyStimulus(2, 8);
      checkOutput("clrSetup", count, 12'h042);
      clr     = 1'b1;
      snapReq = 1'b1;
      @(negedge clk);
      clr     = 1'b0;
      snapReq = 1'b0;
      checkOutput("clrSnapData", snapData, 12'h042);
      checkOutput("clrSnapValid", snapValid, 1);
      checkOutput("clrCount", count, 0);
      checkOutput("clrStarted", started, 0);
      checkOutput("clrMatch", match, 0);
      checkOutput("clrOvr", snapOvr, 0);
      snapReady = 1'b1;
      @(negedge clk);
      snapReady = 1'b0;

      // Randomized traffic, checked by the model and scoreboard
      for (int i = 0; i < 80; i++) begin
         qIn  = CW'($urandom_range(0, 15));
         hold = $urandom_range(1, 6);
         repeat (hold) begin
            snapReq   = ($urandom_range(0, 3) == 0);
            snapReady = 1'($urandom_range(0, 1));
            clr       = ($urandom_range(0, 40) == 0);
            if (clr) thresh = XW'($urandom_range(0, 4095));
            @(negedge clk);
         end
      end
      snapReq   = 1'b0;
      snapReady = 1'b0;
      clr       = 1'b0;

      for (int t = 0; t < 1000 && !dut2Done; t++) @(negedge clk);
      if (!dut2Done) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL dut2Timeout: got done=0, expected done=1 within 1000 cycles");
      end

      // Asynchronous reset in the middle of activity
      applyStimulus(9, 10);
      snapReq = 1'b1;
      @(negedge clk);
      snapReq = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("midRstCount", count, 0);
      checkOutput("midRstStarted", started, 0);
      checkOutput("midRstMatch", match, 0);
      checkOutput("midRstSnapData", snapData, 0);
      checkOutput("midRstSnapValid", snapValid, 0);
      checkOutput("midRstSnapOvr", snapOvr, 0);
      checkOutput("midRstWrapSat", wrapSat, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4, 8);
      checkOutput("postRstCount", count, 12'h004);
      checkOutput("postRstStarted", started, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
